sine_dds_gen: RTL and testbench

Parametrised direct-digital-synthesis sine generator. It is the next-generation signal source behind the TinyTapeout top-level wrapper. A phase accumulator is driven by a frequency tuning word (FTW), and its phase addresses a quarter-wave sine table, producing a signed sample stream with a valid strobe and a cycle-sync pulse. FTW changes are phase-continuous: a new word is applied at the next phase wrap.

---
 rtl/sine_dds_pkg.sv | 24 ++
 rtl/sine_quarter_lut.sv | 30 +++
 rtl/sine_dds_gen.sv | 137 +++++++++++++
 tb/tb_sine_dds_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_dds_pkg.sv
// Shared constants, types and the table-building function for the sine DDS generator.
package sine_dds_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  // Galois form of x^16+x^14+x^13+x^11, shifting right
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Sampled at mid-bin so the quarter wave never lands exactly on 0 or full scale
  function automatic int quarter_sine(input int i, input int addr_w, input int amp_w);
    real ang;
    real amp;
    ang = 3.14159265358979 / 2.0 * (real'(i) + 0.5) / (2.0 ** addr_w);
    amp = (2.0 ** (amp_w - 1)) - 1.0;
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/sine_quarter_lut.sv
// Registered quarter-wave magnitude ROM; forms the second pipeline stage.
module sine_quarter_lut
  import sine_dds_pkg::*;
#(
  parameter int LUT_ADDR_W = 6,
  parameter int AMP_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [AMP_W-2:0]      mag
);

  logic [AMP_W-2:0] rom [2**LUT_ADDR_W];

  for (genvar i = 0; i < 2**LUT_ADDR_W; i++) begin : g_rom
    localparam int V = quarter_sine(i, LUT_ADDR_W, AMP_W);
    assign rom[i] = V[AMP_W-2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
    end else if (rd_en) begin
      mag <= rom[addr];
    end
  end

endmodule

// File: rtl/sine_dds_gen.sv
// Phase-accumulator DDS sine source with phase-continuous FTW updates.
// Optional phase dither enabled by defining SINE_DDS_PHASE_DITHER_EN.
module sine_dds_gen
  import sine_dds_pkg::*;
#(
  parameter int PHASE_W    = 16,
  parameter int LUT_ADDR_W = 6,
  parameter int AMP_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    phase_clr,
  input  logic                    ftw_wr,
  input  logic [PHASE_W-1:0]      ftw_data,
  output logic signed [AMP_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    sync_out,
  output logic                    ftw_pending
);

  logic [PHASE_W-1:0]    acc, ftw_act, ftw_shd, nxt;
  logic [PHASE_W:0]      sum;
  logic                  step, wrap, apply;
  logic                  wrap_p0;
  logic [LUT_ADDR_W+1:0] phase_top;
  quadrant_t             quad;
  logic [LUT_ADDR_W-1:0] idx;
  logic                  vld_p1, sync_p1, neg_p1;
  logic [LUT_ADDR_W-1:0] addr_p1;
  logic                  vld_p2, sync_p2, neg_p2;
  logic [AMP_W-2:0]      mag_p2;

  always_comb begin
    step  = en & ~phase_clr;
    sum   = {1'b0, acc} + {1'b0, ftw_act};
    wrap  = step & sum[PHASE_W];
    nxt   = ftw_wr ? ftw_data : ftw_shd;
    apply = phase_clr | (ftw_act == '0) | (wrap & (ftw_pending | ftw_wr));
  end

  // Stage p0: accumulator, FTW shadow/active pair, and a flag marking an acc reached by wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      ftw_act     <= '0;
      ftw_shd     <= '0;
      ftw_pending <= 1'b0;
      wrap_p0     <= 1'b0;
    end else begin
      if (phase_clr) begin
        acc     <= '0;
        wrap_p0 <= 1'b0;
      end else if (en) begin
        acc     <= sum[PHASE_W-1:0];
        wrap_p0 <= wrap;
      end
      if (ftw_wr) ftw_shd <= ftw_data;
      if (apply) ftw_act <= nxt;
      ftw_pending <= apply ? 1'b0 : (ftw_pending | ftw_wr);
    end
  end

`ifdef SINE_DDS_PHASE_DITHER_EN
  localparam int DITH_W = PHASE_W - LUT_ADDR_W - 2;
  logic [15:0]        lfsr;
  logic [PHASE_W-1:0] dith_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // Dither only perturbs the table address; the accumulator stays exact
  assign dith_sum  = acc + PHASE_W'(lfsr[DITH_W-1:0]);
  assign phase_top = dith_sum[PHASE_W-1 -: LUT_ADDR_W+2];
`else
  assign phase_top = acc[PHASE_W-1 -: LUT_ADDR_W+2];
`endif

  always_comb begin
    quad = quadrant_t'(phase_top[LUT_ADDR_W+1 -: 2]);
    idx  = phase_top[LUT_ADDR_W-1:0];
    if (quad == Q1 || quad == Q3) idx = ~idx;
  end

  // Stage p1: quadrant decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sync_p1 <= 1'b0;
      neg_p1  <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= en;
      sync_p1 <= en & wrap_p0;
      if (en) begin
        neg_p1  <= (quad == Q2 || quad == Q3);
        addr_p1 <= idx;
      end
    end
  end

  // Stage p2: table lookup and sign
  sine_quarter_lut #(
    .LUT_ADDR_W (LUT_ADDR_W),
    .AMP_W      (AMP_W)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_en (vld_p1),
    .addr  (addr_p1),
    .mag   (mag_p2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      sync_p2 <= 1'b0;
      neg_p2  <= 1'b0;
    end else begin
      vld_p2  <= vld_p1;
      sync_p2 <= sync_p1;
      if (vld_p1) neg_p2 <= neg_p1;
    end
  end

  always_comb begin
    sample_out   = neg_p2 ? -$signed({1'b0, mag_p2}) : $signed({1'b0, mag_p2});
    sample_valid = vld_p2;
    sync_out     = sync_p2;
  end

endmodule

// File: tb/tb_sine_dds_gen.sv
// Scoreboard bench for sine_dds_gen at default parameters, dither disabled.
module tb_sine_dds_gen;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              phase_clr = 1'b0;
  logic              ftw_wr = 1'b0;
  logic [15:0]       ftw_data = '0;
  logic signed [7:0] sample_out;
  logic              sample_valid, sync_out, ftw_pending;

  sine_dds_gen #(.PHASE_W(16), .LUT_ADDR_W(6), .AMP_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .phase_clr    (phase_clr),
    .ftw_wr       (ftw_wr),
    .ftw_data     (ftw_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sync_out     (sync_out),
    .ftw_pending  (ftw_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int sy;
    int due;
  } ent_t;

  ent_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_s = 0;
  int   nsync = 0;
  int   last_sync = -1;
  int   sync_period = 0;
  int   min_s = 0;
  int   max_s = 0;
  int   lo_cnt = 0;
  int   clr_cnt = 0;
  bit   sync_chk = 1'b0;

  logic [15:0] m_acc, m_ftw, m_shd;
  logic        m_pend, m_wrapf;

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_sample(input logic [15:0] p);
    int  idx;
    int  m;
    real v;
    idx = int'(p[13:8]);
    if (p[14]) idx = 63 - idx;
    v = 127.0 * $sin(3.14159265358979 * (real'(idx) + 0.5) / 128.0);
    m = $rtoi(v + 0.5);
    return p[15] ? -m : m;
  endfunction

  task automatic model_reset();
    m_acc = '0; m_ftw = '0; m_shd = '0; m_pend = 1'b0; m_wrapf = 1'b0;
    exp_q.delete();
    last_s = 0;
    last_sync = -1;
  endtask

  task automatic monitor();
    ent_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("valid", int'(sample_valid), 1);
      check("sample", int'(sample_out), e.s);
      check("sync", int'(sync_out), e.sy);
      last_s = e.s;
    end else begin
      check("valid_lo", int'(sample_valid), 0);
      check("sync_lo", int'(sync_out), 0);
      check("hold", int'(sample_out), last_s);
    end
    check("pending", int'(ftw_pending), int'(m_pend));
    if (!sample_valid) lo_cnt++;
    if (sample_valid) begin
      if (int'(sample_out) < min_s) min_s = int'(sample_out);
      if (int'(sample_out) > max_s) max_s = int'(sample_out);
      if (clr_cnt > 0) begin
        if (clr_cnt == 3) check("clr_third", int'(sample_out), 2);
        clr_cnt = (clr_cnt == 3) ? 0 : clr_cnt + 1;
      end
      if (sync_out) begin
        if (last_sync >= 0) sync_period = cyc - last_sync;
        last_sync = cyc;
        nsync++;
        if (sync_chk) check("sync_on_pos2", int'(sample_out), 2);
      end
    end
  endtask

  task automatic tick(input bit e, input bit c, input bit w, input logic [15:0] d);
    logic [16:0] sum;
    logic        wrap, apply;
    ent_t        ent;
    en = e; phase_clr = c; ftw_wr = w; ftw_data = d;
    if (e) begin
      ent.s = ref_sample(m_acc);
      ent.sy = int'(m_wrapf);
      ent.due = cyc + 2;
      exp_q.push_back(ent);
    end
    sum   = {1'b0, m_acc} + {1'b0, m_ftw};
    wrap  = e && !c && sum[16];
    apply = c || (m_ftw == 16'h0) || (wrap && (m_pend || w));
    if (c) begin
      m_acc = '0; m_wrapf = 1'b0;
    end else if (e) begin
      m_acc = sum[15:0]; m_wrapf = wrap;
    end
    if (apply) m_ftw = w ? d : m_shd;
    if (w) m_shd = d;
    m_pend = apply ? 1'b0 : (m_pend | w);
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic do_reset();
    en = 1'b0; phase_clr = 1'b0; ftw_wr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_sample", int'(sample_out), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_sync", int'(sync_out), 0);
    check("rst_pending", int'(ftw_pending), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_syncs(input int n, input int bound);
    int start;
    int k;
    start = nsync;
    k = 0;
    while ((nsync - start) < n && k < bound) begin
      tick(1, 0, 0, 16'h0);
      k++;
    end
    if ((nsync - start) < n) check("sync_timeout", nsync - start, n);
  endtask

  initial begin
    int base;
    int k;
    model_reset();
    #1;
    check("por_sample", int'(sample_out), 0);
    check("por_valid", int'(sample_valid), 0);
    check("por_sync", int'(sync_out), 0);
    check("por_pending", int'(ftw_pending), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Quadrant pattern at FTW 0x4000
    tick(0, 0, 1, 16'h4000);
    check("quad_stopped_apply", int'(ftw_pending), 0);
    tick(1, 0, 0, 16'h0);
    tick(1, 0, 0, 16'h0);
    check("quad_s0", int'(sample_out), 2);
    tick(1, 0, 0, 16'h0);
    check("quad_s1", int'(sample_out), 127);
    tick(1, 0, 0, 16'h0);
    check("quad_s2", int'(sample_out), -2);
    tick(1, 0, 0, 16'h0);
    check("quad_s3", int'(sample_out), -127);
    sync_chk = 1'b1;
    run_syncs(3, 40);
    check("quad_period", sync_period, 4);

    // Period and symmetry at FTW 0x0400
    do_reset();
    min_s = 0; max_s = 0;
    tick(0, 0, 1, 16'h0400);
    run_syncs(3, 300);
    check("period_64", sync_period, 64);
    check("peak_pos", max_s, 127);
    check("peak_neg", min_s, -127);

    // Phase-continuous update to 0x0800
    repeat (30) tick(1, 0, 0, 16'h0);
    tick(1, 0, 1, 16'h0800);
    check("pend_set", int'(ftw_pending), 1);
    k = 0;
    while (ftw_pending && k < 80) begin
      tick(1, 0, 0, 16'h0);
      k++;
    end
    check("pend_clr", int'(ftw_pending), 0);
    run_syncs(2, 200);
    check("period_32", sync_period, 32);

    // Write coincident with a wrap
    k = 0;
    while (({1'b0, m_acc} + {1'b0, m_ftw}) <= 17'h0FFFF && k < 64) begin
      tick(1, 0, 0, 16'h0);
      k++;
    end
    tick(1, 0, 1, 16'h1000);
    check("wrap_wr_pend", int'(ftw_pending), 0);
    run_syncs(2, 100);
    check("period_16", sync_period, 16);

    // Stopped start from reset
    do_reset();
    tick(0, 0, 1, 16'h1000);
    check("stop_pend", int'(ftw_pending), 0);
    tick(1, 0, 0, 16'h0);
    tick(1, 0, 0, 16'h0);
    check("stop_first", int'(sample_out), 2);
    run_syncs(2, 100);
    check("stop_period", sync_period, 16);

    // Clear with en, then en low for 5 cycles
    repeat (5) tick(1, 0, 0, 16'h0);
    clr_cnt = 1;
    tick(1, 1, 0, 16'h0);
    repeat (3) tick(1, 0, 0, 16'h0);
    check("clr_done", clr_cnt, 0);
    repeat (3) tick(1, 0, 0, 16'h0);
    lo_cnt = 0;
    repeat (5) tick(0, 0, 0, 16'h0);
    repeat (4) tick(1, 0, 0, 16'h0);
    check("hold_lo_cnt", lo_cnt, 5);

    // Reset mid-run; FTW is lost
    repeat (3) tick(1, 0, 0, 16'h0);
    do_reset();
    base = nsync;
    repeat (20) tick(1, 0, 0, 16'h0);
    check("no_ftw_sync", nsync - base, 0);
    check("no_ftw_sample", int'(sample_out), 2);

    // Random traffic against the model
    sync_chk = 1'b0;
    tick(0, 0, 1, 16'h0123);
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 15) == 0, 16'($urandom));
    end
    repeat (3) tick(0, 0, 0, 16'h0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
